xtile_dbuf_prefetch_loader: RTL and testbench
=============================================

// Module: xtile_dbuf_prefetch_loader
// PURPOSE
//  Multi-row X-tile loader with double-buffered tile banks. It fetches k_count rows
//  (N words each), starting at row k_base, from the external k/n X SRAM into the idle
//  bank while the consumer holds the other bank. It sits between the X SRAM and the
//  MAC array, replacing the single-row loader. It issues up to MAX_OUT pipelined reads
//  and gives the CPU write port absolute priority.
// PARAMETERS
//  N        8          words per row (columns)
//  KMAX     64         rows per tile bank
//  DATA_W   32         word width
//  BYTE_W   DATA_W/8   write-mask width
//  N_W      clog2(N)   column index width (min 1)
//  K_W      clog2(KMAX) row index width (min 1)
//  MAX_OUT  4          max in-flight SRAM reads (tag FIFO depth), >=1
// PORTS
//  clk         in   1               clock
//  rst         in   1               synchronous active-high reset
//  start       in   1               load request; accepted when start & start_ready
//  start_ready out  1               IDLE and at least one bank free
//  k_base      in   K_W             first row to fetch
//  k_count     in   K_W+1           rows to fetch, 1..KMAX
//  err_range   out  1               1-cycle pulse: request truncated or k_count==0
//  tile_valid  out  1               a filled bank is presented
//  tile_accept in   1               consumer releases the presented bank
//  tile_bank   out  1               index of the presented bank
//  X_tile_flat out  KMAX*N*DATA_W   presented bank; word (k,n) at [(k*N+n)*DATA_W +: DATA_W]
//  cpu_x_we/k/n/wdata/wmask  in  1/K_W/N_W/DATA_W/BYTE_W  CPU write port
//  x_en,x_re,x_we  out 1            SRAM controls
//  x_k/x_n/x_wdata/x_wmask out K_W/N_W/DATA_W/BYTE_W  SRAM address and write data
//  x_rdata     in   DATA_W          SRAM read data
//  x_rvalid    in   1               read data valid; returns in issue order, any latency >=1
// BEHAVIOUR
//  - Reset: FSM=IDLE; both banks free; outstanding=0; start_ready=1; tile_valid=0;
//    tile_bank=0; err_range=0; x_en/x_re/x_we=0; bank contents undefined
//    (zeroed when XTILE_ZERO_PAD_EN is defined).
//  - FSM IDLE->ISSUE on accepted start. The fill bank is the free bank (bank 0 if both
//    are free). Effective count = min(k_count, KMAX-k_base); err_range pulses if it
//    truncates or if k_count==0. k_count==0 keeps the FSM in IDLE.
//  - ISSUE: one read per cycle, n-major within a row (k_base,0..N-1, then k_base+1...).
//    A read issues only if outstanding<MAX_OUT and cpu_x_we==0. Each read pushes its
//    (k-k_base, n) tag. The last issue moves the FSM to DRAIN.
//  - CPU priority (combinational mux): cpu_x_we=1 drives x_en=1, x_we=1, x_re=0 and
//    the CPU address/data. The loader read that cycle stalls and no issue counter
//    advances.
//  - Each x_rvalid pops a tag and writes x_rdata to fill_bank[k][n] in the same edge.
//    outstanding +1 on issue, -1 on rvalid; both in one cycle leave it unchanged.
//    x_rvalid with an empty FIFO is ignored.
//  - DRAIN->IDLE when outstanding==0. The fill bank is marked full.
//  - Presentation: tile_valid=1 while any bank is full. With both banks full, the older
//    one is presented first. tile_accept&tile_valid frees the presented bank next cycle.
//    If the other bank is full, tile_valid stays 1 and tile_bank toggles.
//  - Bank release and completion of the other bank in the same cycle: both updates apply.
//  - start_ready=0 outside IDLE or with both banks full. Start while not ready is ignored.
//  - Rows are stored at offset k-k_base (row 0 = k_base). Rows >= effective count keep
//    stale data unless XTILE_ZERO_PAD_EN is defined.
//  - rst mid-load: in-flight reads abandoned; later x_rvalid ignored (FIFO empty).
// CONFIGURATION
//  XTILE_ZERO_PAD_EN defined: on start accept the fill bank is cleared to 0 in the same
//    edge, so unfetched rows read as zero.
//  XTILE_ZERO_PAD_EN undefined: no clear; unfetched rows keep prior contents.
//  Both modes: identical timing, no added latency.
// TESTING
//  1 CPU writes (k,n)=k*16+n for all rows; start k_base=0,k_count=2, SRAM lat 1 ->
//    16 reads in 16 cycles, tile_valid, bank0 row1 n3 = 0x13.
//  2 SRAM latency 6, MAX_OUT=4 -> x_re never high with 4 in flight; data intact.
//  3 cpu_x_we held 3 cycles mid-ISSUE -> no reads those cycles, x_k/x_n = CPU values;
//    load completes 3 cycles late, no dropped or duplicated words.
//  4 Two back-to-back starts, no accept -> bank0 presented, start_ready=0 after second
//    load; tile_accept -> tile_bank=1 next cycle, start_ready=1.
//  5 k_base=KMAX-2, k_count=5 -> err_range 1 cycle, 2 rows fetched; rows 2..4 = 0 with
//    XTILE_ZERO_PAD_EN, else prior data.
//  6 rst asserted during DRAIN, then stale x_rvalid -> all outputs at reset values,
//    no bank write, next load correct.

Source files
------------

// File: rtl/xtile_dbuf_prefetch_loader.sv
// Double-buffered multi-row X-tile loader with pipelined, in-order SRAM reads and CPU write priority.
// Optional macro XTILE_ZERO_PAD_EN: the fill bank reads as zero until each word is fetched.
module xtile_dbuf_prefetch_loader #(
    parameter int N       = 8,
    parameter int KMAX    = 64,
    parameter int DATA_W  = 32,
    parameter int BYTE_W  = DATA_W / 8,
    parameter int N_W     = (N > 1) ? $clog2(N) : 1,
    parameter int K_W     = (KMAX > 1) ? $clog2(KMAX) : 1,
    parameter int MAX_OUT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     start_ready,
    input  logic [K_W-1:0]           k_base,
    input  logic [K_W:0]             k_count,
    output logic                     err_range,
    output logic                     tile_valid,
    input  logic                     tile_accept,
    output logic                     tile_bank,
    output logic [KMAX*N*DATA_W-1:0] X_tile_flat,
    input  logic                     cpu_x_we,
    input  logic [K_W-1:0]           cpu_x_k,
    input  logic [N_W-1:0]           cpu_x_n,
    input  logic [DATA_W-1:0]        cpu_x_wdata,
    input  logic [BYTE_W-1:0]        cpu_x_wmask,
    output logic                     x_en,
    output logic                     x_re,
    output logic                     x_we,
    output logic [K_W-1:0]           x_k,
    output logic [N_W-1:0]           x_n,
    output logic [DATA_W-1:0]        x_wdata,
    output logic [BYTE_W-1:0]        x_wmask,
    input  logic [DATA_W-1:0]        x_rdata,
    input  logic                     x_rvalid
);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int IDX_W = K_W + N_W;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [K_W:0]       KMAX_L  = (K_W+1)'(KMAX);
    localparam logic [K_W:0]       ONE_C   = (K_W+1)'(1);
    localparam logic [K_W-1:0]     ONE_K   = K_W'(1);
    localparam logic [N_W-1:0]     ONE_N   = N_W'(1);
    localparam logic [N_W-1:0]     N_LAST  = N_W'(N - 1);
    localparam logic [OUT_W-1:0]   OUT_MAX = OUT_W'(MAX_OUT);
    localparam logic [OUT_W-1:0]   ONE_O   = OUT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       r_full;
    logic             r_older;
    logic             r_fill;
    logic             r_err;
    logic [OUT_W-1:0] r_out;
    logic [K_W-1:0]   r_kbase;
    logic [K_W:0]     r_cnt;
    logic [K_W-1:0]   r_ik;
    logic [N_W-1:0]   r_in;
    logic [K_W-1:0]   r_rk;
    logic [N_W-1:0]   r_rn;
    logic [DATA_W-1:0] r_bank [2][KMAX*N];

    logic [K_W:0]     w_room;
    logic [K_W:0]     w_eff;
    logic             w_trunc;
    logic             w_zero;
    logic             w_start_acc;
    logic             w_load;
    logic             w_issue;
    logic             w_last_issue;
    logic             w_ret;
    logic             w_done;
    logic             w_release;
    logic [1:0]       w_full_nxt;
    logic [IDX_W-1:0] w_widx;

    assign w_room       = KMAX_L - {1'b0, k_base};
    assign w_trunc      = (k_count > w_room);
    assign w_zero       = (k_count == '0);
    assign w_eff        = w_trunc ? w_room : k_count;
    assign start_ready  = (r_state == S_IDLE) && !(&r_full);
    assign w_start_acc  = start && start_ready;
    assign w_load       = w_start_acc && !w_zero;
    assign w_issue      = (r_state == S_ISSUE) && (r_out < OUT_MAX) && !cpu_x_we;
    assign w_last_issue = w_issue && (r_in == N_LAST) && ({1'b0, r_ik} == (r_cnt - ONE_C));
    // Returns with nothing outstanding belong to an abandoned load and are dropped.
    assign w_ret        = x_rvalid && (r_out != '0) && !rst;
    assign w_done       = (r_state == S_DRAIN) && (r_out == '0);
    assign w_widx       = IDX_W'(r_rk) * IDX_W'(N) + IDX_W'(r_rn);

    assign tile_valid   = |r_full;
    assign tile_bank    = (&r_full) ? r_older : r_full[1];
    assign w_release    = tile_valid && tile_accept;
    assign err_range    = r_err;

    // CPU writes own the SRAM port outright; the loader read simply stalls.
    assign x_we    = cpu_x_we;
    assign x_re    = w_issue;
    assign x_en    = cpu_x_we || w_issue;
    assign x_k     = cpu_x_we ? cpu_x_k : (r_kbase + r_ik);
    assign x_n     = cpu_x_we ? cpu_x_n : r_in;
    assign x_wdata = cpu_x_wdata;
    assign x_wmask = cpu_x_wmask;

    always_comb begin
        w_full_nxt = r_full;
        if (w_release) w_full_nxt[tile_bank] = 1'b0;
        if (w_done)    w_full_nxt[r_fill]    = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_full  <= '0;
            r_older <= 1'b0;
            r_fill  <= 1'b0;
            r_err   <= 1'b0;
            r_out   <= '0;
            r_kbase <= '0;
            r_cnt   <= '0;
            r_ik    <= '0;
            r_in    <= '0;
            r_rk    <= '0;
            r_rn    <= '0;
        end else begin
            r_err  <= w_start_acc && (w_zero || w_trunc);
            r_full <= w_full_nxt;
            // The bank completing now is the younger one if its partner stays full.
            if (w_done) r_older <= w_full_nxt[~r_fill] ? ~r_fill : r_fill;
            if (w_issue && !w_ret)      r_out <= r_out + ONE_O;
            else if (!w_issue && w_ret) r_out <= r_out - ONE_O;
            case (r_state)
                S_IDLE: begin
                    if (w_load) begin
                        r_state <= S_ISSUE;
                        r_fill  <= r_full[0];
                        r_kbase <= k_base;
                        r_cnt   <= w_eff;
                        r_ik    <= '0;
                        r_in    <= '0;
                        r_rk    <= '0;
                        r_rn    <= '0;
                    end
                end
                S_ISSUE: if (w_last_issue) r_state <= S_DRAIN;
                S_DRAIN: if (w_done) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_issue) begin
                if (r_in == N_LAST) begin
                    r_in <= '0;
                    r_ik <= r_ik + ONE_K;
                end else begin
                    r_in <= r_in + ONE_N;
                end
            end
            // Reads return in issue order, so a second counter stands in for the tag FIFO.
            if (w_ret) begin
                if (r_rn == N_LAST) begin
                    r_rn <= '0;
                    r_rk <= r_rk + ONE_K;
                end else begin
                    r_rn <= r_rn + ONE_N;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ret) r_bank[r_fill][w_widx] <= x_rdata;
    end

`ifdef XTILE_ZERO_PAD_EN
    logic [KMAX*N-1:0] r_wval [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wval[0] <= '0;
            r_wval[1] <= '0;
        end else if (w_load) begin
            r_wval[r_full[0]] <= '0;
        end else if (w_ret) begin
            r_wval[r_fill][w_widx] <= 1'b1;
        end
    end

    for (genvar g = 0; g < KMAX*N; g++) begin : g_out
        assign X_tile_flat[g*DATA_W +: DATA_W] = r_wval[tile_bank][g] ? r_bank[tile_bank][g] : '0;
    end
`else
    for (genvar g = 0; g < KMAX*N; g++) begin : g_out
        assign X_tile_flat[g*DATA_W +: DATA_W] = r_bank[tile_bank][g];
    end
`endif

endmodule

// File: tb/tb_xtile_dbuf_prefetch_loader.sv
// Randomized bench for xtile_dbuf_prefetch_loader: SRAM responder with variable latency,
// bank contents predicted per load from a word-level memory image and a presentation queue.
module tb_xtile_dbuf_prefetch_loader;
    localparam int N       = 8;
    localparam int KMAX    = 64;
    localparam int DATA_W  = 32;
    localparam int BYTE_W  = 4;
    localparam int N_W     = 3;
    localparam int K_W     = 6;
    localparam int MAX_OUT = 4;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     start = 1'b0;
    logic                     start_ready;
    logic [K_W-1:0]           k_base = '0;
    logic [K_W:0]             k_count = '0;
    logic                     err_range;
    logic                     tile_valid;
    logic                     tile_accept = 1'b0;
    logic                     tile_bank;
    logic [KMAX*N*DATA_W-1:0] X_tile_flat;
    logic                     cpu_x_we = 1'b0;
    logic [K_W-1:0]           cpu_x_k = '0;
    logic [N_W-1:0]           cpu_x_n = '0;
    logic [DATA_W-1:0]        cpu_x_wdata = '0;
    logic [BYTE_W-1:0]        cpu_x_wmask = '0;
    logic                     x_en, x_re, x_we;
    logic [K_W-1:0]           x_k;
    logic [N_W-1:0]           x_n;
    logic [DATA_W-1:0]        x_wdata;
    logic [BYTE_W-1:0]        x_wmask;
    logic [DATA_W-1:0]        x_rdata = '0;
    logic                     x_rvalid = 1'b0;

    xtile_dbuf_prefetch_loader dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .k_base(k_base), .k_count(k_count), .err_range(err_range),
        .tile_valid(tile_valid), .tile_accept(tile_accept), .tile_bank(tile_bank),
        .X_tile_flat(X_tile_flat),
        .cpu_x_we(cpu_x_we), .cpu_x_k(cpu_x_k), .cpu_x_n(cpu_x_n),
        .cpu_x_wdata(cpu_x_wdata), .cpu_x_wmask(cpu_x_wmask),
        .x_en(x_en), .x_re(x_re), .x_we(x_we), .x_k(x_k), .x_n(x_n),
        .x_wdata(x_wdata), .x_wmask(x_wmask), .x_rdata(x_rdata), .x_rvalid(x_rvalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [KMAX][N];
    logic [DATA_W-1:0] exp_b [2][KMAX][N];
    bit                known [2][KMAX];
    int                pres_q[$];
    logic [DATA_W-1:0] q_data[$];
    int                q_due[$];
    int cyc = 0, lat = 1;
    int n_issue = 0, n_ret = 0, first_iss = -1, last_iss = -1;
    int inflight = 0, max_infl = 0, over_viol = 0, cpu_viol = 0;
    int tgt_ret = 0, cur_fb = 0;

    // SRAM responder and port monitor, evaluated away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (x_rvalid) begin
            n_ret++;
            inflight--;
        end
        if (x_en && x_re) begin
            if (inflight >= MAX_OUT) over_viol++;
            if (x_we) cpu_viol++;
            q_data.push_back(mem[x_k][x_n]);
            q_due.push_back(cyc + lat);
            n_issue++;
            if (first_iss < 0) first_iss = cyc;
            last_iss = cyc;
            inflight++;
            if (inflight > max_infl) max_infl = inflight;
        end
        if (cpu_x_we) begin
            if (!(x_en && x_we) || x_re || x_k !== cpu_x_k || x_n !== cpu_x_n ||
                x_wdata !== cpu_x_wdata || x_wmask !== cpu_x_wmask) cpu_viol++;
            for (int b = 0; b < BYTE_W; b++)
                if (cpu_x_wmask[b]) mem[cpu_x_k][cpu_x_n][8*b +: 8] = cpu_x_wdata[8*b +: 8];
        end
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            x_rvalid = 1'b1;
            x_rdata  = q_data.pop_front();
            void'(q_due.pop_front());
        end else begin
            x_rvalid = 1'b0;
            x_rdata  = $urandom;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        n_issue = 0; first_iss = -1; last_iss = -1;
        max_infl = 0; over_viol = 0; cpu_viol = 0;
        inflight = q_due.size() + (x_rvalid ? 1 : 0);
    endtask

    task automatic model_reset();
        pres_q.delete();
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < KMAX; r++) begin
`ifdef XTILE_ZERO_PAD_EN
                known[b][r] = 1'b1;
                for (int n = 0; n < N; n++) exp_b[b][r][n] = '0;
`else
                known[b][r] = known[b][r];
`endif
            end
    endtask

    task automatic cpu_wr(input int k, input int n, input logic [DATA_W-1:0] d, input logic [BYTE_W-1:0] m);
        cpu_x_we = 1'b1; cpu_x_k = K_W'(k); cpu_x_n = N_W'(n); cpu_x_wdata = d; cpu_x_wmask = m;
        @(posedge clk); #1;
        cpu_x_we = 1'b0;
    endtask

    task automatic start_load(input int base, input int cnt);
        int eff, fb;
        bit exp_err;
        eff = (cnt > KMAX - base) ? KMAX - base : cnt;
        exp_err = (cnt == 0) || (cnt > KMAX - base);
        fb = 0;
        foreach (pres_q[i]) if (pres_q[i] == 0) fb = 1;
        checks++;
        if (start_ready !== (pres_q.size() < 2)) begin
            errors++;
            $display("FAIL start_ready_pre_load: got %b want %b", start_ready, pres_q.size() < 2);
        end
        k_base = K_W'(base); k_count = (K_W+1)'(cnt); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (err_range !== exp_err) begin
            errors++;
            $display("FAIL err_range_on_start base=%0d cnt=%0d: got %b want %b", base, cnt, err_range, exp_err);
        end
        if (cnt != 0) begin
            for (int r = 0; r < KMAX; r++) begin
                if (r < eff) begin
                    known[fb][r] = 1'b1;
                    for (int n = 0; n < N; n++) exp_b[fb][r][n] = mem[base + r][n];
                end else begin
`ifdef XTILE_ZERO_PAD_EN
                    known[fb][r] = 1'b1;
                    for (int n = 0; n < N; n++) exp_b[fb][r][n] = '0;
`endif
                end
            end
            cur_fb = fb;
            tgt_ret = n_ret + eff * N;
        end
    endtask

    task automatic wait_load();
        int t = 0;
        while (n_ret < tgt_ret && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (n_ret < tgt_ret) begin
            errors++;
            $display("FAIL load_timeout: returns got %0d want %0d", n_ret, tgt_ret);
        end
        repeat (2) begin @(posedge clk); #1; end
        pres_q.push_back(cur_fb);
    endtask

    task automatic accept();
        tile_accept = 1'b1;
        @(posedge clk); #1;
        tile_accept = 1'b0;
        if (pres_q.size() > 0) void'(pres_q.pop_front());
    endtask

    task automatic check_bank(input string name);
        int b, bad;
        logic [DATA_W-1:0] got, want;
        string where;
        if (pres_q.size() == 0) begin
            checks++;
            if (tile_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_tile_valid: got %b want 0", name, tile_valid);
            end
        end else begin
            b = pres_q[0];
            checks++;
            if (tile_valid !== 1'b1 || tile_bank !== b[0]) begin
                errors++;
                $display("FAIL %s_present: tile_valid=%b tile_bank=%b want valid=1 bank=%0d", name, tile_valid, tile_bank, b);
            end
            bad = 0;
            where = "";
            for (int k = 0; k < KMAX; k++)
                if (known[b][k])
                    for (int n = 0; n < N; n++) begin
                        got = X_tile_flat[(k*N + n)*DATA_W +: DATA_W];
                        want = exp_b[b][k][n];
                        if (got !== want) begin
                            if (bad == 0) where = $sformatf("k=%0d n=%0d got %h want %h", k, n, got, want);
                            bad++;
                        end
                    end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL %s_data: %0d words wrong, first %s", name, bad, where);
            end
        end
    endtask

    task automatic test_reset();
        for (int b = 0; b < 2; b++) for (int r = 0; r < KMAX; r++) known[b][r] = 1'b0;
        for (int k = 0; k < KMAX; k++) for (int n = 0; n < N; n++) mem[k][n] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        checks++;
        if (start_ready !== 1'b1 || tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: start_ready=%b tile_valid=%b want 1/0", start_ready, tile_valid);
        end
        checks++;
        if (tile_bank !== 1'b0 || err_range !== 1'b0) begin
            errors++;
            $display("FAIL reset_bank_err: tile_bank=%b err_range=%b want 0/0", tile_bank, err_range);
        end
        checks++;
        if ({x_en, x_re, x_we} !== 3'b000) begin
            errors++;
            $display("FAIL reset_sram_ctl: en/re/we=%b want 000", {x_en, x_re, x_we});
        end
        for (int k = 0; k < KMAX; k++)
            for (int n = 0; n < N; n++) cpu_wr(k, n, DATA_W'(k*16 + n), 4'hF);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_basic();
        lat = 1;
        clear_mon();
        start_load(0, 2);
        wait_load();
        checks++;
        if (n_issue != 16 || last_iss - first_iss != 15) begin
            errors++;
            $display("FAIL basic_issue: reads=%0d span=%0d want 16/15", n_issue, last_iss - first_iss);
        end
        checks++;
        if (X_tile_flat[(1*N + 3)*DATA_W +: DATA_W] !== 32'h13) begin
            errors++;
            $display("FAIL basic_word_1_3: got %h want 00000013", X_tile_flat[(1*N + 3)*DATA_W +: DATA_W]);
        end
        check_bank("basic");
        accept();
        check_bank("basic_released");
    endtask

    task automatic test_latency();
        int b;
        lat = 6;
        b = $urandom_range(0, KMAX - 3);
        for (int k = b; k < b + 3; k++)
            for (int n = 0; n < N; n++) cpu_wr(k, n, $urandom, 4'hF);
        clear_mon();
        start_load(b, 3);
        wait_load();
        checks++;
        if (over_viol != 0 || max_infl != MAX_OUT || n_issue != 24) begin
            errors++;
            $display("FAIL latency_outstanding: over=%0d max=%0d reads=%0d want 0/%0d/24", over_viol, max_infl, n_issue, MAX_OUT);
        end
        check_bank("latency");
        accept();
    endtask

    task automatic test_cpu_priority();
        int b;
        lat = 1;
        b = $urandom_range(0, 50);
        clear_mon();
        start_load(b, 4);
        repeat (5) begin @(posedge clk); #1; end
        for (int i = 0; i < 3; i++) begin
            cpu_x_we = 1'b1; cpu_x_k = K_W'(63); cpu_x_n = N_W'(i);
            cpu_x_wdata = $urandom; cpu_x_wmask = BYTE_W'($urandom_range(1, 15));
            #1;
            checks++;
            if (x_re !== 1'b0 || x_we !== 1'b1 || x_k !== K_W'(63) || x_n !== N_W'(i)) begin
                errors++;
                $display("FAIL cpu_mux_%0d: re=%b we=%b k=%0d n=%0d want 0/1/63/%0d", i, x_re, x_we, x_k, x_n, i);
            end
            @(posedge clk); #1;
        end
        cpu_x_we = 1'b0;
        wait_load();
        checks++;
        if (n_issue != 32 || last_iss - first_iss != 34 || cpu_viol != 0) begin
            errors++;
            $display("FAIL cpu_stall: reads=%0d span=%0d viol=%0d want 32/34/0", n_issue, last_iss - first_iss, cpu_viol);
        end
        check_bank("cpu_priority");
        accept();
    endtask

    task automatic test_back_to_back();
        lat = $urandom_range(1, 4);
        clear_mon();
        start_load(3, 2);
        wait_load();
        start_load(10, 1);
        wait_load();
        checks++;
        if (tile_bank !== 1'b0 || start_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_both_full: tile_bank=%b start_ready=%b want 0/0", tile_bank, start_ready);
        end
        check_bank("b2b_first");
        accept();
        checks++;
        if (tile_valid !== 1'b1 || tile_bank !== 1'b1 || start_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after_accept: valid=%b bank=%b ready=%b want 1/1/1", tile_valid, tile_bank, start_ready);
        end
        check_bank("b2b_second");
        start_load(20, 3);
        wait_load();
        checks++;
        if (tile_bank !== 1'b1) begin
            errors++;
            $display("FAIL b2b_older_first: tile_bank=%b want 1", tile_bank);
        end
        check_bank("b2b_older");
        accept();
        check_bank("b2b_newer");
        accept();
        check_bank("b2b_empty");
    endtask

    task automatic test_truncate();
        lat = $urandom_range(1, 3);
        clear_mon();
        start_load(KMAX - 2, 5);
        @(posedge clk); #1;
        checks++;
        if (err_range !== 1'b0) begin
            errors++;
            $display("FAIL trunc_err_width: err_range=%b want 0 on second cycle", err_range);
        end
        wait_load();
        checks++;
        if (n_issue != 16) begin
            errors++;
            $display("FAIL trunc_reads: got %0d want 16", n_issue);
        end
        check_bank("truncate");
        accept();
        clear_mon();
        start_load(5, 0);
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (n_issue != 0 || start_ready !== 1'b1 || tile_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_count: reads=%0d ready=%b valid=%b want 0/1/0", n_issue, start_ready, tile_valid);
        end
    endtask

    task automatic test_rst_mid();
        int t = 0;
        lat = 6;
        clear_mon();
        start_load(0, 3);
        while (n_issue < 24 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        checks++;
        if (n_issue < 24) begin
            errors++;
            $display("FAIL rst_mid_issue_timeout: reads=%0d want 24", n_issue);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int r = 0; r < 3; r++) known[cur_fb][r] = 1'b0;
        model_reset();
        checks++;
        if (start_ready !== 1'b1 || tile_valid !== 1'b0 || tile_bank !== 1'b0 ||
            err_range !== 1'b0 || x_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b valid=%b bank=%b err=%b en=%b want 1/0/0/0/0",
                     start_ready, tile_valid, tile_bank, err_range, x_en);
        end
        repeat (10) begin @(posedge clk); #1; end
        checks++;
        if (start_ready !== 1'b1 || tile_valid !== 1'b0 || x_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_stale: ready=%b valid=%b en=%b want 1/0/0", start_ready, tile_valid, x_en);
        end
        lat = 2;
        clear_mon();
        start_load(7, 1);
        wait_load();
        checks++;
        if (n_issue != 8) begin
            errors++;
            $display("FAIL rst_mid_reload_reads: got %0d want 8", n_issue);
        end
        check_bank("rst_mid_reload");
        accept();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_cpu_priority();
        test_back_to_back();
        test_truncate();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
